// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and address field constants
// for the 2-way write-through data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1,
    WRITE
  } state_e;

  localparam int WORD_SEL  = 2;
  localparam int INDEX_LSB = 3;
  localparam int LINE_W    = 64;
  localparam int WAYS      = 2;

  function automatic int tag_lsb(input int idx_w);
    return INDEX_LSB + idx_w;
  endfunction

endpackage

// File: rtl/cache_set_array.sv
// cache_set_array: valid/tag/data/LRU storage for a 2-way cache,
// combinational lookup plus fill, invalidate and LRU update ports.
module cache_set_array
  import cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 10,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic              word_sel,
  output logic              hit,
  output logic              hit_way,
  output logic [31:0]       hit_word,
  output logic              victim,
  input  logic              lru_upd,
  input  logic              lru_val,
  input  logic              fill_en,
  input  logic              fill_way,
  input  logic [LINE_W-1:0] fill_data,
  input  logic              inv_en,
  input  logic              inv_way
);

  logic [WAYS-1:0][SETS-1:0] valid;
  logic [SETS-1:0]           lru;
  logic [TAG_W-1:0]          tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]         data_mem [WAYS][SETS];
  logic [WAYS-1:0]           match;
  logic [LINE_W-1:0]         line;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid[w][idx] && (tag_mem[w][idx] == tag);
    end
    hit      = |match;
    hit_way  = match[1];
    line     = data_mem[hit_way][idx];
    hit_word = word_sel ? line[63:32] : line[31:0];
    // An empty way is always filled before anything is evicted
    if (!valid[0][idx])
      victim = 1'b0;
    else if (!valid[1][idx])
      victim = 1'b1;
    else
      victim = lru[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      lru   <= '0;
    end else begin
      if (fill_en)
        valid[fill_way][idx] <= 1'b1;
      if (inv_en)
        valid[inv_way][idx] <= 1'b0;
      if (lru_upd)
        lru[idx] <= lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_way][idx]  <= tag;
      data_mem[fill_way][idx] <= fill_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way read cache, write-through, no write-allocate.
// Optional hit/miss counters when CACHE_STATS_EN is defined.
module cache_controller
  import cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = tag_lsb(IDX_W);

  state_e             state;
  logic [31:0]        word0;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               hit_way;
  logic [31:0]        hit_word;
  logic               victim;
  logic               rd_req;
  logic               rd_hit;
  logic               rd_miss;
  logic               fill_done;
  logic               write_done;

  assign idx = address[INDEX_LSB +: IDX_W];
  assign tag = address[TAG_LSB +: TAG_W];

  assign rd_req     = (state == IDLE) && rd_en && !wr_en;
  assign rd_hit     = rd_req && hit;
  assign rd_miss    = rd_req && !hit;
  assign fill_done  = (state == FILL1) && sram_rd_en && sram_ready;
  assign write_done = (state == WRITE) && sram_wr_en && sram_ready;

  always_comb begin
    ready = fill_done || write_done ||
            ((state == IDLE) && !wr_en && !rd_miss);
    rdata = '0;
    if (rd_hit)
      rdata = hit_word;
    else if (fill_done)
      rdata = address[WORD_SEL] ? sram_rdata : word0;
  end

  cache_set_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .tag       (tag),
    .word_sel  (address[WORD_SEL]),
    .hit       (hit),
    .hit_way   (hit_way),
    .hit_word  (hit_word),
    .victim    (victim),
    .lru_upd   (rd_hit || fill_done),
    .lru_val   (rd_hit ? ~hit_way : ~victim),
    .fill_en   (fill_done),
    .fill_way  (victim),
    .fill_data ({sram_rdata, word0}),
    .inv_en    ((state == IDLE) && wr_en && hit),
    .inv_way   (hit_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word0        <= '0;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_en) begin
            state        <= WRITE;
            sram_wr_en   <= 1'b1;
            sram_address <= address;
            sram_wdata   <= wdata;
          end else if (rd_miss) begin
            state        <= FILL0;
            sram_rd_en   <= 1'b1;
            sram_address <= {address[31:3], 3'b000};
          end
        end
        FILL0: begin
          if (sram_ready) begin
            state        <= FILL1;
            word0        <= sram_rdata;
            sram_address <= {address[31:3], 3'b100};
          end
        end
        FILL1: begin
          if (sram_ready) begin
            state        <= IDLE;
            sram_rd_en   <= 1'b0;
            sram_address <= '0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state        <= IDLE;
            sram_wr_en   <= 1'b0;
            sram_address <= '0;
            sram_wdata   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (rd_miss && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized and directed checks of the cache
// against an SRAM responder and a recency-list cache model.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // SRAM responder and backing memory
  logic [31:0] mem [logic [29:0]];
  int          lat = 0;
  int          rcnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          unstable = 0;
  logic [31:0] hold_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] rd_log [$];

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem.exists(wa))
      return mem[wa];
    return {wa[15:0] ^ 16'h5A5A, wa[15:0]};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sram_ready = 1'b0;
        rcnt = 0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
        rcnt = 0;
      end else if (sram_rd_en || sram_wr_en) begin
        if (sram_rd_en && sram_wr_en)
          unstable++;
        if (rcnt == 0)
          hold_addr = sram_address;
        else if (sram_address !== hold_addr)
          unstable++;
        if (rcnt >= lat) begin
          sram_ready = 1'b1;
          if (sram_rd_en) begin
            sram_rdata = mem_rd(sram_address[31:2]);
            n_rd++;
            rd_log.push_back(sram_address);
          end else begin
            mem[sram_address[31:2]] = sram_wdata;
            last_wr_addr = sram_address;
            last_wr_data = sram_wdata;
            n_wr++;
          end
        end
        rcnt++;
      end
    end
  end

  // Cache model: per set, tags ordered most-recent first, at most two
  logic [9:0] rq [64][$];
  int exp_hits = 0;
  int exp_misses = 0;

  function automatic bit model_lookup(input logic [31:0] a);
    int s;
    logic [9:0] t;
    s = int'(a[8:3]);
    t = a[18:9];
    for (int i = 0; i < rq[s].size(); i++) begin
      if (rq[s][i] == t) begin
        rq[s].delete(i);
        rq[s].push_front(t);
        exp_hits++;
        return 1'b1;
      end
    end
    if (rq[s].size() == 2)
      void'(rq[s].pop_back());
    rq[s].push_front(t);
    exp_misses++;
    return 1'b0;
  endfunction

  function automatic void model_write(input logic [31:0] a);
    int s;
    s = int'(a[8:3]);
    for (int i = 0; i < rq[s].size(); i++) begin
      if (rq[s][i] == a[18:9]) begin
        rq[s].delete(i);
        break;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++)
      rq[i].delete();
    exp_hits = 0;
    exp_misses = 0;
  endfunction

  int last_cyc = 0;
  int en_drop = 0;

  task automatic do_read(input logic [31:0] a, output logic hit,
                         output logic [31:0] d);
    int cyc;
    cyc = 0;
    @(negedge clk);
    rd_en = 1'b1;
    wr_en = 1'b0;
    address = a;
    forever begin
      #1;
      if (ready) break;
      if (cyc >= 300) begin
        n_vec++;
        n_err++;
        $display("FAIL read_timeout addr=%h ready=0 required=1", a);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    hit = (cyc == 0);
    d = rdata;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd,
                          input bit also_rd);
    int cyc;
    cyc = 0;
    en_drop = 0;
    @(negedge clk);
    wr_en = 1'b1;
    rd_en = also_rd;
    address = a;
    wdata = wd;
    forever begin
      #1;
      if (ready) break;
      if (cyc > 0 && sram_wr_en !== 1'b1)
        en_drop++;
      if (cyc >= 300) begin
        n_vec++;
        n_err++;
        $display("FAIL write_timeout addr=%h ready=0 required=1", a);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sram_rd_en, sram_wr_en, ready} !== 3'b001 ||
        sram_address !== 32'h0 || sram_wdata !== 32'h0 ||
        rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs got rd=%b wr=%b rdy=%b a=%h wd=%h rd=%h required 0 0 1 0 0 0",
               sram_rd_en, sram_wr_en, ready, sram_address, sram_wdata, rdata);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    logic hit;
    logic [31:0] d;
    int n0;
    apply_reset();
    lat = 1;
    mem[30'h102] = 32'h1111;
    mem[30'h103] = 32'h2222;
    rd_log.delete();
    void'(model_lookup(32'h408));
    do_read(32'h408, hit, d);
    n_vec++;
    if (hit !== 1'b0 || d !== 32'h1111) begin
      n_err++;
      $display("FAIL cold_read got hit=%b data=%h required 0 00001111", hit, d);
    end
    n_vec++;
    if (rd_log.size() != 2 || rd_log[0] !== 32'h408 || rd_log[1] !== 32'h40C) begin
      n_err++;
      $display("FAIL cold_addrs got n=%0d required 2 reads 408,40c", rd_log.size());
    end
    n0 = n_rd;
    void'(model_lookup(32'h40C));
    do_read(32'h40C, hit, d);
    n_vec++;
    if (hit !== 1'b1 || d !== 32'h2222 || n_rd != n0) begin
      n_err++;
      $display("FAIL warm_read got hit=%b data=%h reads=%0d required 1 00002222 0",
               hit, d, n_rd - n0);
    end
  endtask

  task automatic test_replacement();
    logic [31:0] seq [6];
    bit          exp [6];
    logic        hit;
    logic [31:0] d;
    seq = '{32'h1008, 32'h2008, 32'h1008, 32'h3008, 32'h1008, 32'h2008};
    exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      void'(model_lookup(seq[i]));
      do_read(seq[i], hit, d);
      n_vec++;
      if (hit !== exp[i] || d !== mem_rd(seq[i][31:2])) begin
        n_err++;
        $display("FAIL replace_%0d got hit=%b data=%h required %b %h",
                 i, hit, d, exp[i], mem_rd(seq[i][31:2]));
      end
    end
  endtask

  task automatic test_write_inval();
    logic hit;
    logic [31:0] d;
    int w0;
    apply_reset();
    lat = 3;
    void'(model_lookup(32'h408));
    do_read(32'h408, hit, d);
    void'(model_lookup(32'h408));
    do_read(32'h408, hit, d);
    n_vec++;
    if (hit !== 1'b1) begin
      n_err++;
      $display("FAIL inval_prehit got hit=%b required 1", hit);
    end
    w0 = n_wr;
    model_write(32'h408);
    do_write(32'h408, 32'hDEAD, 1'b0);
    n_vec++;
    if (en_drop != 0 || n_wr - w0 != 1 || last_wr_addr !== 32'h408 ||
        last_wr_data !== 32'hDEAD) begin
      n_err++;
      $display("FAIL write_txn got drops=%0d n=%0d a=%h d=%h required 0 1 408 dead",
               en_drop, n_wr - w0, last_wr_addr, last_wr_data);
    end
    void'(model_lookup(32'h408));
    do_read(32'h408, hit, d);
    n_vec++;
    if (hit !== 1'b0 || d !== 32'hDEAD) begin
      n_err++;
      $display("FAIL inval_read got hit=%b data=%h required 0 0000dead", hit, d);
    end
  endtask

  task automatic test_stall();
    logic hit;
    logic [31:0] d;
    int n0;
    apply_reset();
    lat = 5;
    unstable = 0;
    n0 = n_rd;
    void'(model_lookup(32'h5A0));
    do_read(32'h5A0, hit, d);
    n_vec++;
    if (n_rd - n0 != 2 || unstable != 0 || last_cyc != 2 * 5 + 3 ||
        d !== mem_rd(30'h168)) begin
      n_err++;
      $display("FAIL stall got reads=%0d unstable=%0d cycles=%0d data=%h required 2 0 13 %h",
               n_rd - n0, unstable, last_cyc, d, mem_rd(30'h168));
    end
  endtask

  task automatic test_reset_mid_fill();
    logic hit;
    logic [31:0] d;
    int n0;
    int cyc;
    apply_reset();
    lat = 20;
    n0 = n_rd;
    @(negedge clk);
    rd_en = 1'b1;
    address = 32'h7C4;
    cyc = 0;
    while (n_rd == n0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (sram_rd_en !== 1'b1 || sram_address !== 32'h7C4) begin
      n_err++;
      $display("FAIL fill1_reach got en=%b addr=%h required 1 000007c4",
               sram_rd_en, sram_address);
    end
    rst = 1'b1;
    rd_en = 1'b0;
    #1;
    n_vec++;
    if (sram_rd_en !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL midfill_reset got en=%b ready=%b required 0 1", sram_rd_en, ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    void'(model_lookup(32'h7C4));
    do_read(32'h7C4, hit, d);
    n_vec++;
    if (hit !== 1'b0 || d !== mem_rd(30'h1F1)) begin
      n_err++;
      $display("FAIL after_reset_read got hit=%b data=%h required 0 %h",
               hit, d, mem_rd(30'h1F1));
    end
  endtask

  task automatic test_rd_wr_together();
    int r0;
    int w0;
    apply_reset();
    lat = 2;
    r0 = n_rd;
    w0 = n_wr;
    model_write(32'h210);
    do_write(32'h210, 32'hCAFE0001, 1'b1);
    n_vec++;
    if (n_rd != r0 || n_wr - w0 != 1 || last_wr_data !== 32'hCAFE0001) begin
      n_err++;
      $display("FAIL rd_wr_both got reads=%0d writes=%0d data=%h required 0 1 cafe0001",
               n_rd - r0, n_wr - w0, last_wr_data);
    end
  endtask

  task automatic test_stats();
    logic [31:0] seq [5];
    logic hit;
    logic [31:0] d;
    seq = '{32'h0800, 32'h0800, 32'h0C08, 32'h0C0C, 32'h0804};
    apply_reset();
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      void'(model_lookup(seq[i]));
      do_read(seq[i], hit, d);
    end
    n_vec++;
    if (exp_hits != 3 || exp_misses != 2) begin
      n_err++;
      $display("FAIL stats_model got %0d/%0d required 3/2", exp_hits, exp_misses);
    end
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_count !== 16'd3 || miss_count !== 16'd2) begin
      n_err++;
      $display("FAIL stats_counts got hit=%0d miss=%0d required 3 2",
               hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] d;
    logic        hit;
    bit          exp_hit;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      lat = int'($urandom_range(0, 2));
      a = {13'h0, 10'($urandom_range(0, 3)), 6'($urandom_range(0, 2)),
           1'($urandom), 2'b00};
      if ($urandom_range(0, 9) < 7) begin
        exp_hit = model_lookup(a);
        do_read(a, hit, d);
        n_vec++;
        if (hit !== exp_hit || d !== mem_rd(a[31:2])) begin
          n_err++;
          $display("FAIL rand_read_%0d addr=%h got hit=%b data=%h required %b %h",
                   i, a, hit, d, exp_hit, mem_rd(a[31:2]));
        end
      end else begin
        wd = $urandom;
        model_write(a);
        do_write(a, wd, 1'b0);
        n_vec++;
        if (last_wr_addr !== a || last_wr_data !== wd || en_drop != 0) begin
          n_err++;
          $display("FAIL rand_write_%0d got a=%h d=%h drops=%0d required %h %h 0",
                   i, last_wr_addr, last_wr_data, en_drop, a, wd);
        end
      end
    end
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
      n_err++;
      $display("FAIL rand_stats got hit=%0d miss=%0d required %0d %0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_replacement();
    test_write_inval();
    test_stall();
    test_reset_mid_fill();
    test_rd_wr_together();
    test_stats();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
